// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// default bit timing, parity/stop constants and the parity helper.
package uart_pkg;

    // Default bit period: 100 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Parity selection values.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;

    // Stop bit counts.
    localparam int STOP_ONE = 1;
    localparam int STOP_TWO = 2;

    // 3-bit state codes for the transmitter FSM.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_FETCH  = S_FETCH,
        ST_LOAD   = S_LOAD,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } state_t;

    // Even parity: the appended bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period with bit_tick.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running bit timer that wraps at the end of each bit and is held at zero when cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bit_tick = en && !clear && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Consumer side of the byte FIFO: pops one byte at a time and serialises it
// as an 8N1 / 8E1 / 8N2 / 8E2 UART frame on tx. The FIFO read data arrives one
// cycle after the pop, so a LOAD state sits between FETCH and START.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = PARITY_NONE,
    parameter int STOP_BITS    = STOP_ONE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    // Value of the stop counter during the final stop bit.
    localparam logic STOP_LAST = (STOP_BITS == STOP_TWO);

    state_t     state;
    state_t     next_state;
    logic [7:0] shift;
    logic [7:0] shift_next;
    logic       parity_bit;
    logic       parity_next;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_next;
    logic       stop_cnt;
    logic       stop_cnt_next;
    logic       tx_next;
    logic       baud_en;
    logic       bit_tick;

    // Bit timing only runs while a frame is on the wire; it restarts from zero on every START.
    assign baud_en = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (!baud_en),
        .en       (baud_en),
        .bit_tick (bit_tick)
    );

    // State, shifter, counters and the registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift      <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state      <= next_state;
            shift      <= shift_next;
            parity_bit <= parity_next;
            bit_idx    <= bit_idx_next;
            stop_cnt   <= stop_cnt_next;
            tx         <= tx_next;
        end
    end

    // Next-state logic, datapath updates and the FIFO pop / frame-done strobes.
    always_comb begin
        next_state    = state;
        shift_next    = shift;
        parity_next   = parity_bit;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;
        fifo_rd_en    = 1'b0;
        tx_done       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fifo_rd_en = 1'b1;
                next_state = ST_LOAD;
            end
            ST_LOAD: begin
                shift_next    = fifo_data;
                parity_next   = even_parity(fifo_data);
                bit_idx_next  = '0;
                stop_cnt_next = 1'b0;
                next_state    = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_next   = {1'b0, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        next_state = (PARITY_EN == PARITY_EVEN) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        tx_done    = 1'b1;
                        next_state = (enable && !fifo_empty) ? ST_FETCH : ST_IDLE;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so tx is registered yet aligned with the state.
    always_comb begin
        tx_next = 1'b1;
        case (next_state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = parity_next;
            default:   tx_next = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: two instances (8N1 and 8E2) fed by behavioural
// FIFO models; a line monitor decodes frames and checks them against a
// scoreboard of bytes written into each FIFO.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] enable;
    logic [1:0] fifo_empty = 2'b11;
    logic [1:0] fifo_rd_en;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] tx_done;
    logic [7:0] data_a = 8'h00;
    logic [7:0] data_b = 8'h00;
    logic [1:0] wr_en;
    logic [7:0] wr_data;

    int cyc = 0;
    int rd_count [2] = '{0, 0};
    int rd_cyc   [2] = '{0, 0};
    int errors = 0;
    int checks = 0;

    logic [7:0] mem_a [$];
    logic [7:0] mem_b [$];
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    int         gap_a [$];

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
        .fifo_rd_en(fifo_rd_en[0]), .fifo_data(data_a), .tx(tx[0]),
        .busy(busy[0]), .tx_done(tx_done[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
        .fifo_rd_en(fifo_rd_en[1]), .fifo_data(data_b), .tx(tx[1]),
        .busy(busy[1]), .tx_done(tx_done[1])
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int expSize(input int idx);
        return (idx == 0) ? exp_a.size() : exp_b.size();
    endfunction

    function automatic logic [7:0] expPop(input int idx);
        return (idx == 0) ? exp_a.pop_front() : exp_b.pop_front();
    endfunction

    // Cycle counter plus two registered-read FIFO models; rd_cyc records the FETCH cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en[0]) mem_a.push_back(wr_data);
        if (wr_en[1]) mem_b.push_back(wr_data);
        if (fifo_rd_en[0]) begin
            checkOutput("no_underflow_a", int'(fifo_empty[0]), 0);
            if (mem_a.size() > 0) data_a <= mem_a.pop_front();
            rd_count[0] <= rd_count[0] + 1;
            rd_cyc[0]   <= cyc;
        end
        if (fifo_rd_en[1]) begin
            checkOutput("no_underflow_b", int'(fifo_empty[1]), 0);
            if (mem_b.size() > 0) data_b <= mem_b.pop_front();
            rd_count[1] <= rd_count[1] + 1;
            rd_cyc[1]   <= cyc;
        end
        fifo_empty[0] <= (mem_a.size() == 0);
        fifo_empty[1] <= (mem_b.size() == 0);
    end

    // Writes one byte into the chosen FIFO and records it as the next expected frame.
    task automatic applyStimulus(input int idx, input logic [7:0] b);
        wr_data     = b;
        wr_en[idx]  = 1'b1;
        if (idx == 0) exp_a.push_back(b);
        else          exp_b.push_back(b);
        @(posedge clk); #1;
        wr_en[idx]  = 1'b0;
    endtask

    task automatic waitIdle(input int idx, input int limit);
        int n;
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            if (!busy[idx] && fifo_empty[idx] && expSize(idx) == 0) break;
            n++;
        end
        checkOutput("idle_timeout", int'(n < limit), 1);
        @(posedge clk); #1;
    endtask

    // Decodes frames from the line and compares them with the scoreboard.
    task automatic monitorLine(input int idx, input int par, input int stops);
        int         nbits;
        int         len;
        int         start;
        int         last_end;
        int         bad;
        int         first_done;
        int         done_cnt;
        int         ones;
        bit         aborted;
        logic       s [64];
        logic       d [64];
        logic [7:0] got;
        logic [7:0] want;
        nbits    = 1 + 8 + par + stops;
        len      = nbits * CPB;
        last_end = -1000;
        forever begin
            @(negedge clk);
            if (!rst && tx_done[idx]) checkOutput("stray_tx_done", 1, 0);
            if (!rst && tx[idx] == 1'b0) begin
                start   = cyc;
                aborted = 1'b0;
                s[0]    = tx[idx];
                d[0]    = tx_done[idx];
                for (int k = 1; k < len; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[k] = tx[idx];
                    d[k] = tx_done[idx];
                end
                if (!aborted) begin
                    bad = 0;
                    for (int b = 0; b < nbits; b++)
                        for (int c = 0; c < CPB; c++)
                            if (s[b*CPB + c] != s[b*CPB]) bad++;
                    checkOutput("bit_hold", bad, 0);
                    for (int i = 0; i < 8; i++) got[i] = s[(1 + i) * CPB];
                    if (expSize(idx) == 0) begin
                        checkOutput("unexpected_frame", int'(got), -1);
                    end else begin
                        want = expPop(idx);
                        checkOutput("frame_data", int'(got), int'(want));
                        if (par != 0) begin
                            ones = 0;
                            for (int i = 0; i < 8; i++) if (want[i]) ones++;
                            checkOutput("parity_bit", int'(s[9*CPB]), ones % 2);
                        end
                    end
                    bad = 0;
                    for (int i = 0; i < stops; i++) if (s[(9 + par + i) * CPB] != 1'b1) bad++;
                    checkOutput("stop_bits", bad, 0);
                    first_done = -1;
                    done_cnt   = 0;
                    for (int k = 0; k < len; k++) begin
                        if (d[k]) begin
                            done_cnt++;
                            if (first_done < 0) first_done = k;
                        end
                    end
                    checkOutput("tx_done_pos", first_done, len - 1);
                    checkOutput("tx_done_count", done_cnt, 1);
                    checkOutput("rd_to_start", start - rd_cyc[idx], 2);
                    if (idx == 0) gap_a.push_back(start - last_end - 1);
                    last_end = start + len - 1;
                end
            end
        end
    endtask

    initial monitorLine(0, 0, 1);
    initial monitorLine(1, 1, 2);

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r0;
        int n;
        int dones;
        int fall;
        rst     = 1'b1;
        enable  = 2'b00;
        wr_en   = 2'b00;
        wr_data = 8'h00;
        @(posedge clk); #1;

        // Reset held with a non-empty FIFO: line idle, no pop, not busy.
        enable = 2'b11;
        applyStimulus(0, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_fifo_not_empty", int'(fifo_empty[0]), 0);
            checkOutput("reset_tx", int'(tx[0]), 1);
            checkOutput("reset_rd_en", int'(fifo_rd_en[0]), 0);
            checkOutput("reset_busy", int'(busy[0]), 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;

        // Single byte 0xA5 is sent after exactly one pop.
        waitIdle(0, 300);
        checkOutput("single_rd_count", rd_count[0], 1);

        // Three queued bytes go out back-to-back with two-cycle gaps.
        r0 = rd_count[0];
        gap_a.delete();
        applyStimulus(0, 8'h00);
        applyStimulus(0, 8'hFF);
        applyStimulus(0, 8'h3C);
        n = 0;
        while (!busy[0] && n < 50) begin @(negedge clk); n++; end
        dones = 0;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (tx_done[0]) dones++;
            if (!busy[0]) break;
            n++;
        end
        checkOutput("busy_falls_after_third", dones, 3);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("burst_rd_count", rd_count[0] - r0, 3);
        checkOutput("burst_frames", gap_a.size(), 3);
        if (gap_a.size() == 3) begin
            checkOutput("gap_frame2", gap_a[1], 2);
            checkOutput("gap_frame3", gap_a[2], 2);
        end

        // 8E2 instance: byte 0x07, busy spans FETCH + LOAD + 48-cycle frame.
        applyStimulus(1, 8'h07);
        n = 0;
        while (n < 50) begin @(negedge clk); if (busy[1]) break; n++; end
        n = 0;
        while (busy[1] && n < 200) begin n++; @(negedge clk); end
        checkOutput("e2_busy_cycles", n, 50);
        waitIdle(1, 300);

        // Disable mid-frame: frame completes, second byte waits for re-enable.
        r0 = rd_count[0];
        applyStimulus(0, 8'h5A);
        applyStimulus(0, 8'hC3);
        n = 0;
        while (tx[0] && n < 50) begin @(negedge clk); n++; end
        repeat (9) begin @(posedge clk); #1; end
        enable[0] = 1'b0;
        n = 0;
        while (busy[0] && n < 200) begin @(negedge clk); n++; end
        repeat (20) begin @(posedge clk); #1; end
        checkOutput("disable_one_pop", rd_count[0] - r0, 1);
        checkOutput("disable_idle", int'(busy[0]), 0);
        enable[0] = 1'b1;
        waitIdle(0, 300);
        checkOutput("reenable_second_pop", rd_count[0] - r0, 2);

        // Reset during data bit 3: line returns high, byte dropped, next pop one cycle after release.
        applyStimulus(0, 8'h96);
        applyStimulus(0, 8'h3D);
        n = 0;
        while (n < 50) begin @(negedge clk); if (!tx[0]) break; n++; end
        r0 = rd_count[0];
        repeat (17) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        fall = cyc;
        if (exp_a.size() > 0) void'(exp_a.pop_front());
        @(negedge clk);
        checkOutput("midreset_tx_high", int'(tx[0]), 1);
        checkOutput("midreset_idle", int'(busy[0]), 0);
        n = 0;
        while (rd_count[0] == r0 && n < 20) begin @(negedge clk); n++; end
        checkOutput("midreset_rd_latency", rd_cyc[0] - fall, 1);
        waitIdle(0, 300);

        // Randomised traffic on both instances with enable toggling on the 8N1 one.
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(0, 1);
            applyStimulus(n, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) enable[0] = ~enable[0];
            repeat ($urandom_range(0, 25)) begin @(posedge clk); #1; end
        end
        enable = 2'b11;
        waitIdle(0, 3000);
        waitIdle(1, 3000);
        checkOutput("drain_a", exp_a.size(), 0);
        checkOutput("drain_b", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
